// File: rtl/btn_mem_port_if.sv
// Button/RAM-port bundle between board I/O and btn_mem_port.
// The board side drives the buttons and din. The port returns the address, the read data and status pulses.
interface btn_mem_port_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              inc_button;
    logic              dec_button;
    logic              wr_button;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;
    logic              delta;
    logic              wrote;

    modport master (
        output inc_button, dec_button, wr_button, din,
        input  addr, dout, delta, wrote
    );

    modport slave (
        input  inc_button, dec_button, wr_button, din,
        output addr, dout, delta, wrote
    );
endinterface

// File: rtl/btn_mem_port.sv
// Single RAM port stepped by debounced, auto-repeating inc/dec buttons.
// A debounced write button stores din at the current address.
module btn_mem_port #(
    parameter int DATA_W          = 16,
    parameter int ADDR_W          = 10,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter bit WRAP            = 1'b1,
    parameter bit REPEAT_EN       = 1'b1
) (
    input logic          CLK,
    input logic          reset,
    btn_mem_port_if.slave bus
);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_W   = $clog2(RP_MAX + 1);
    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0]   DELAY_LOAD = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0]   RATE_LOAD  = RP_W'(REPEAT_RATE - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

    // Button index: 0 = inc, 1 = dec, 2 = wr
    logic [2:0]      raw, sync1, sync2, stable, press;
    logic [DB_W-1:0] db_cnt [3];

    assign raw = {bus.wr_button, bus.dec_button, bus.inc_button};

    always_ff @(posedge CLK) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            press  <= '0;
            for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                    press[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    rep_state_t      rep_state [2];
    logic [RP_W-1:0] rep_cnt   [2];
    logic [1:0]      rep_fire, step;

    // Counters are loaded with N-1 so that the step is consumed exactly N edges after the previous one.
    always_comb begin
        rep_fire = '0;
        step     = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            rep_fire[i] = REPEAT_EN && (rep_state[i] != IDLE) && (rep_cnt[i] == '0) && stable[i];
            step[i]     = press[i] | rep_fire[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                rep_state[i] <= IDLE;
                rep_cnt[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                case (rep_state[i])
                    IDLE: begin
                        if (press[i] && REPEAT_EN) begin
                            rep_state[i] <= DELAY;
                            rep_cnt[i]   <= DELAY_LOAD;
                        end
                    end
                    DELAY, REPEAT: begin
                        if (!stable[i]) begin
                            rep_state[i] <= IDLE;
                        end else if (rep_cnt[i] == '0) begin
                            rep_state[i] <= REPEAT;
                            rep_cnt[i]   <= RATE_LOAD;
                        end else begin
                            rep_cnt[i] <= rep_cnt[i] - 1'b1;
                        end
                    end
                    default: rep_state[i] <= IDLE;
                endcase
            end
        end
    end

    logic [ADDR_W-1:0] addr_q, addr_next;
    logic [DATA_W-1:0] dout_q;
    logic              up, dn, accept, wr_en;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_comb begin
        up        = step[0] & ~step[1];
        dn        = step[1] & ~step[0];
        accept    = 1'b0;
        addr_next = addr_q;
        if (up && (WRAP || addr_q != ADDR_MAX)) begin
            accept    = 1'b1;
            addr_next = addr_q + 1'b1;
        end else if (dn && (WRAP || addr_q != '0)) begin
            accept    = 1'b1;
            addr_next = addr_q - 1'b1;
        end
    end

    assign wr_en     = press[2] & ~reset;
    assign bus.delta = accept & ~reset;
    assign bus.wrote = wr_en;
    assign bus.addr  = addr_q;
    assign bus.dout  = dout_q;

    always_ff @(posedge CLK) begin
        if (wr_en) mem[addr_q] <= bus.din;
    end

    // Read the next address so dout lines up with addr; bypass din when writing the word being read.
    always_ff @(posedge CLK) begin
        if (reset) begin
            addr_q <= '0;
            dout_q <= '0;
        end else begin
            addr_q <= addr_next;
            dout_q <= (wr_en && addr_next == addr_q) ? bus.din : mem[addr_next];
        end
    end
endmodule
